// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer arbiter and its helpers.
// Pixel format is {R[3:0],G[3:0],B[3:0]}; addresses are linear y*FB_W+x.
package fb_pkg;

  localparam int FB_W     = 320;
  localparam int FB_H     = 240;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int AW       = 17;
  localparam int DW       = 12;

  localparam logic [1:0] SLOT_DISP = 2'd0;
  localparam logic [1:0] SLOT_CAP  = 2'd1;
  localparam logic [1:0] SLOT_LAST = 2'd3;

  typedef enum logic {
    H_IDLE,
    H_ACK
  } host_state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Maps a 640x480 display coordinate onto the 2x-downscaled frame buffer.
// Shift-add form of y*320 + x so no multiplier is inferred.
module fb_addr_calc
  import fb_pkg::*;
(
  input  logic [9:0]    i_h,
  input  logic [9:0]    i_v,
  output logic [AW-1:0] o_addr
);

  logic [AW-1:0] w_x;
  logic [AW-1:0] w_y;
  logic          w_unused;

  assign w_x = AW'(i_h[9:1]);
  assign w_y = AW'(i_v[9:1]);

  // 320 = 256 + 64
  assign o_addr = (w_y << 8) + (w_y << 6) + w_x;

  // The LSBs are dropped by the 2x upscale.
  assign w_unused = i_h[0] ^ i_v[0];

endmodule

// File: rtl/frame_mem_arbiter.sv
// Shares one single-port frame-buffer BRAM between VGA scan-out (slot 0 of
// every pixel period) and a req/ack host port that gets all remaining cycles.
module frame_mem_arbiter
  import fb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic [9:0]    h_cnt,
  input  logic [9:0]    v_cnt,
  input  logic          valid,
  output logic [3:0]    vgaRed,
  output logic [3:0]    vgaGreen,
  output logic [3:0]    vgaBlue,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          host_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic [1:0]    r_slot;
  logic          r_capValid;
  logic [DW-1:0] r_rgb;
  host_state_t   r_hstate;
  logic          r_isRead;
  logic          r_err;

  logic [1:0]    w_slot;
  logic [AW-1:0] w_dispAddr;
  logic          w_dispRd;
  logic          w_hostEligible;
  logic          w_issue;
  logic          w_inRange;
  logic          w_hostAccess;

  fb_addr_calc u_addr_calc (
    .i_h    (h_cnt),
    .i_v    (v_cnt),
    .o_addr (w_dispAddr)
  );

  // Memory strobes are combinational, so they are gated with the reset level
  // to keep the BRAM quiet while reset is held.
  assign w_slot         = pix_en ? SLOT_DISP : r_slot;
  assign w_dispRd       = rst && (w_slot == SLOT_DISP) && valid;
  assign w_hostEligible = (w_slot != SLOT_DISP) || !valid;
  assign w_issue        = rst && host_req && (r_hstate == H_IDLE) && w_hostEligible;
  assign w_inRange      = host_addr < AW'(FB_DEPTH);
  assign w_hostAccess   = w_issue && w_inRange;

  always_comb begin
    mem_en    = w_dispRd || w_hostAccess;
    mem_we    = w_hostAccess && host_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_dispRd) begin
      mem_addr = w_dispAddr;
    end else if (w_hostAccess) begin
      mem_addr  = host_addr;
      mem_wdata = host_we ? host_wdata : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot     <= SLOT_LAST;
      r_capValid <= 1'b0;
      r_rgb      <= '0;
    end else begin
      r_slot     <= (w_slot == SLOT_LAST) ? SLOT_LAST : w_slot + 2'd1;
      r_capValid <= w_dispRd;
      if (w_slot == SLOT_CAP) begin
        r_rgb <= r_capValid ? mem_rdata : '0;
      end
    end
  end

  // Read data arrives from the BRAM during H_ACK, so ack/rdata decode
  // straight from the state rather than adding another register stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hstate <= H_IDLE;
      r_isRead <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_hstate)
        H_IDLE: begin
          if (w_issue) begin
            r_hstate <= H_ACK;
            r_isRead <= !host_we && w_inRange;
            r_err    <= !w_inRange;
          end
        end
        H_ACK:   r_hstate <= H_IDLE;
        default: r_hstate <= H_IDLE;
      endcase
    end
  end

  assign host_ack   = (r_hstate == H_ACK);
  assign host_rdata = (host_ack && r_isRead) ? mem_rdata : '0;
  assign host_err   = host_ack && r_err;

  assign vgaRed   = r_rgb[11:8];
  assign vgaGreen = r_rgb[7:4];
  assign vgaBlue  = r_rgb[3:0];

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed self-checking bench for frame_mem_arbiter with a behavioural BRAM
// preloaded with addr[11:0]; host responses are checked through a queue.
module tb_frame_mem_arbiter;
  import fb_pkg::*;

  typedef struct packed {
    logic [11:0] rdata;
    logic        err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_en;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic          valid;
  logic [3:0]    vgaRed;
  logic [3:0]    vgaGreen;
  logic [3:0]    vgaBlue;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          host_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   lastAck = -10;
  logic peOn;
  int   phase;
  exp_t q[$];
  exp_t eHead;
  logic [11:0] bram [int];
  logic [11:0] shadow [int];

  frame_mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .valid      (valid),
    .vgaRed     (vgaRed),
    .vgaGreen   (vgaGreen),
    .vgaBlue    (vgaBlue),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .host_err   (host_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port BRAM with one-cycle registered read; unwritten words read as addr[11:0].
  always @(posedge clk) begin
    if (mem_en && (int'(mem_addr) < 76800)) begin
      if (mem_we) bram[int'(mem_addr)] = mem_wdata;
      else mem_rdata <= bram.exists(int'(mem_addr)) ? bram[int'(mem_addr)] : mem_addr[11:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] expRead(input int a);
    if (a >= 76800) return 12'h000;
    if (shadow.exists(a)) return shadow[a];
    return 12'(a);
  endfunction

  function automatic int dispModel(input int h, input int v);
    return (v / 2) * 320 + (h / 2);
  endfunction

  task automatic pushRead(input int a);
    exp_t e;
    e.rdata = expRead(a);
    e.err   = (a >= 76800);
    q.push_back(e);
  endtask

  task automatic pushWrite(input int a, input logic [11:0] d);
    exp_t e;
    e.rdata = 12'h000;
    e.err   = 1'b0;
    q.push_back(e);
    shadow[a] = d;
  endtask

  // Advance one clock and regenerate the 1-in-4 pixel strobe.
  task automatic tick();
    @(posedge clk);
    #1;
    pix_en = peOn && (phase == 0);
    phase  = (phase + 1) % 4;
  endtask

  task automatic toSlot0();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pix_en) break;
    end
  endtask

  // Host ack scoreboard, ack spacing and display-slot ownership monitor.
  always @(negedge clk) begin
    if (host_ack) begin
      if (q.size() == 0) begin
        check("ack_unexpected", 32'(host_ack), 32'd0);
      end else begin
        eHead = q.pop_front();
        check("ack_rdata", 32'(host_rdata), 32'(eHead.rdata));
        check("ack_err", 32'(host_err), 32'(eHead.err));
      end
      check("ack_spacing", 32'((cyc - lastAck) >= 2), 32'd1);
      lastAck = cyc;
    end
    if (rst && pix_en && valid) begin
      check("disp_en", 32'(mem_en), 32'd1);
      check("disp_we", 32'(mem_we), 32'd0);
      check("disp_addr", 32'(mem_addr), 32'(dispModel(int'(h_cnt), int'(v_cnt))));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int addrs[5];
    int nAck;
    int waited;
    int idx;
    logic sawAck;

    addrs = '{100, 200, 965, 4095, 76799};
    rst = 1'b0; pix_en = 1'b0; valid = 1'b0; h_cnt = '0; v_cnt = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    peOn = 1'b0; phase = 0;

    // Reset values, with active-looking inputs applied during reset.
    repeat (2) @(posedge clk);
    #1;
    pix_en = 1'b1; valid = 1'b1; h_cnt = 10'd10; v_cnt = 10'd6;
    host_req = 1'b1; host_addr = 17'd5;
    @(negedge clk);
    check("rst_rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 32'd0);
    check("rst_ack", 32'(host_ack), 32'd0);
    check("rst_rdata", 32'(host_rdata), 32'd0);
    check("rst_err", 32'(host_err), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    @(posedge clk);
    #1;
    host_req = 1'b0; pix_en = 1'b0; rst = 1'b1; peOn = 1'b1; phase = 0;

    // Scan-out: h=10, v=6 -> address 965, pixel 12'h3C5 two clocks later.
    toSlot0();
    @(negedge clk);
    check("s1_mem_addr", 32'(mem_addr), 32'd965);
    tick();
    @(negedge clk);
    check("s1_rgb_early", 32'({vgaRed, vgaGreen, vgaBlue}), 32'd0);
    tick();
    @(negedge clk);
    check("s1_rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 32'h3C5);

    // Blank pixel period: host write takes slot 0, RGB goes to zero.
    valid = 1'b0;
    toSlot0();
    host_req = 1'b1; host_we = 1'b1; host_addr = 17'd200; host_wdata = 12'h5A5;
    pushWrite(200, 12'h5A5);
    @(negedge clk);
    check("s2_mem_en", 32'(mem_en), 32'd1);
    check("s2_mem_we", 32'(mem_we), 32'd1);
    check("s2_mem_addr", 32'(mem_addr), 32'd200);
    tick();
    @(negedge clk);
    check("s2_ack", 32'(host_ack), 32'd1);
    tick();
    host_req = 1'b0;
    @(negedge clk);
    check("s2_no_dup_ack", 32'(host_ack), 32'd0);
    check("s2_rgb_blank", 32'({vgaRed, vgaGreen, vgaBlue}), 32'd0);

    // Host write collides with the display slot and slips to slot 1.
    valid = 1'b1;
    toSlot0();
    host_req = 1'b1; host_we = 1'b1; host_addr = 17'd100; host_wdata = 12'hABC;
    pushWrite(100, 12'hABC);
    @(negedge clk);
    check("s3_slot0_we", 32'(mem_we), 32'd0);
    check("s3_slot0_ack", 32'(host_ack), 32'd0);
    tick();
    @(negedge clk);
    check("s3_issue_addr", 32'(mem_addr), 32'd100);
    check("s3_issue_we", 32'(mem_we), 32'd1);
    check("s3_issue_wdata", 32'(mem_wdata), 32'hABC);
    tick();
    @(negedge clk);
    check("s3_ack", 32'(host_ack), 32'd1);
    tick();
    host_we = 1'b0;
    pushRead(100);
    @(negedge clk);
    check("s3_rd_issue_en", 32'(mem_en), 32'd1);
    check("s3_rd_issue_addr", 32'(mem_addr), 32'd100);
    tick();
    @(negedge clk);
    check("s3_rd_ack", 32'(host_ack), 32'd1);
    tick();
    host_req = 1'b0;

    // Out-of-range read: no BRAM access, error ack.
    host_req = 1'b1; host_we = 1'b0; host_addr = 17'd76800;
    pushRead(76800);
    @(negedge clk);
    check("s4_mem_en", 32'(mem_en), 32'd0);
    tick();
    @(negedge clk);
    check("s4_ack", 32'(host_ack), 32'd1);
    tick();
    host_req = 1'b0;

    // Back-to-back reads with req held while scan-out is active.
    host_req = 1'b1; host_we = 1'b0; host_addr = AW'(addrs[0]);
    pushRead(addrs[0]);
    idx = 1; nAck = 0; waited = 0;
    while (nAck < 5 && waited < 40) begin
      @(negedge clk);
      sawAck = host_ack;
      tick();
      waited++;
      if (sawAck) begin
        nAck++;
        if (idx < 5) begin
          host_addr = AW'(addrs[idx]);
          pushRead(addrs[idx]);
          idx++;
        end else begin
          host_req = 1'b0;
        end
      end
    end
    check("s5_ack_count", 32'(nAck), 32'd5);
    check("s5_queue_empty", 32'(q.size()), 32'd0);

    // Reset lands in the H_ACK cycle: the pending read is dropped silently.
    valid = 1'b0;
    tick();
    host_req = 1'b1; host_we = 1'b0; host_addr = 17'd300;
    @(negedge clk);
    check("s6_issue_en", 32'(mem_en), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0; host_req = 1'b0; peOn = 1'b0; pix_en = 1'b0;
    @(negedge clk);
    check("s6_ack", 32'(host_ack), 32'd0);
    check("s6_rdata", 32'(host_rdata), 32'd0);
    check("s6_rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 32'd0);
    check("s6_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("s6_ack_hold", 32'(host_ack), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1; peOn = 1'b1; phase = 0; valid = 1'b1; h_cnt = 10'd10; v_cnt = 10'd6;
    toSlot0();
    @(negedge clk);
    check("s6_disp_addr", 32'(mem_addr), 32'd965);
    tick();
    tick();
    @(negedge clk);
    check("s6_rgb_after", 32'({vgaRed, vgaGreen, vgaBlue}), 32'h3C5);
    tick();
    tick();
    @(negedge clk);
    check("final_queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_mem_arbiter.md
# frame_mem_arbiter

Arbitrates a single-port 320×240×12-bit frame-buffer BRAM between VGA scan-out and a host read/write port. Runs on the 100 MHz system clock and uses a 1-in-4 pixel-enable strobe. Scan-out has guaranteed slots. The host gets every remaining memory cycle through a req/ack handshake. Sits between the VGA timing generator (h_cnt, v_cnt, valid) and the RGB outputs, in place of a combinational pixel generator.

## Interface
- FB_W, 320: frame-buffer width in pixels; display is 2× upscaled.
- FB_H, 240: frame-buffer height.
- AW, 17: memory address width; FB_W*FB_H = 76800 < 2^17.
- DW, 12: pixel width, {R[3:0],G[3:0],B[3:0]}.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- pix_en  in  1  one-cycle strobe every 4 clk, aligned with h_cnt/v_cnt updates.
- h_cnt, v_cnt  in  10 each  current display pixel, 0..639 / 0..479 when valid.
- valid  in  1  display-active flag.
- vgaRed, vgaGreen, vgaBlue  out  4 each  registered pixel colour.
- host_req  in  1  host access request, held until host_ack.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  AW  linear address, y*320+x.
- host_wdata  in  DW  write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DW  read data, valid with host_ack.
- host_err  out  1  pulses with host_ack when host_addr ≥ 76800.
- mem_en, mem_we  out  1 each  BRAM strobes.
- mem_addr  out  AW; mem_wdata  out  DW.
- mem_rdata  in  DW  registered BRAM output, 1-cycle read latency.

## Operation
- Slot counter (2 bits):
  - The cycle with pix_en=1 is slot 0.
  - The counter then advances to 1, 2, 3 and saturates at 3 until the next pix_en.
  - pix_en always forces slot 0, even mid-sequence.
- Slot 0 with valid=1 is the display read:
  - mem_en=1, mem_we=0.
  - mem_addr = (v_cnt>>1)*320 + (h_cnt>>1), computed as (v>>1)<<8 + (v>>1)<<6 + (h>>1).
  - The host cannot issue in this slot.
- Slot 1: capture the display pixel. RGB register ← mem_rdata if the slot-0 valid (registered) was 1, else 12'h000.
- Host issue rules:
  - The host may issue in slots 1–3, and in slot 0 when valid=0.
  - Issue requires host_req=1 and host FSM in H_IDLE.
- Host FSM states:
  - H_IDLE: on issue, drive mem_en=1, mem_we=host_we, mem_addr=host_addr, mem_wdata=host_wdata, then go to H_ACK.
  - H_ACK: host_ack=1, host_rdata=mem_rdata for reads (0 for writes), then go to H_IDLE. req is ignored in this cycle.
- Out-of-range host_addr: no memory access (mem_en=0), but still goes to H_ACK with host_rdata=0 and host_err=1.
- Only one host transaction is outstanding at a time. The host must hold req/we/addr/wdata stable until ack. Sampling occurs at issue.
- Simultaneous host_req and display slot: display wins and the host issues in the next allowed cycle. No starvation: slots 1–3 are always host-eligible.
- Scan-out mode: mem_en=0 in cycles with no issue; mem_we=0 except during a host write.

## Timing
- Reset values: vga*=0, host_ack=0, host_rdata=0, host_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. Slot=3, host FSM=H_IDLE.
- Reset mid-transaction drops the pending host op with no ack.
- Display latency: RGB updates on the clk edge ending slot 1, i.e. 2 clk after the pix_en edge. It is then held until the next slot 1.
- Host latency:
  - host_ack is exactly 1 cycle after issue.
  - Worst-case issue wait is 2 cycles (blocked by slot 0, then the display-capture cycle is still eligible).
  - Minimum issue-to-issue spacing is 2 cycles.
- mem_* outputs are combinational from slot/FSM state, or registered; both are allowed provided the 1-cycle BRAM contract and the above latencies hold at the port.

## Structure
- Shared package fb_pkg:
  - constants FB_W, FB_H, FB_DEPTH=76800, AW, DW;
  - slot encoding SLOT_DISP=0, SLOT_CAP=1;
  - host FSM enum {H_IDLE, H_ACK}.
- Sub-module fb_addr_calc: combinational (h_cnt, v_cnt) → AW-bit linear address using shift-add, no multiplier. Reused by host-side drawing logic.

## Test plan
- Scan-out, memory preloaded with addr[11:0] as data, h=10, v=6 valid → mem_addr=3*320+5=965 in slot 0; RGB=12'h3C5 two clk after pix_en.
- valid=0 on a pix_en → no display read; RGB=0 after slot 1. A host write issued in that slot 0 → ack next cycle.
- host_req write addr=100 data=12'hABC asserted in slot 0 with valid=1 → issue in slot 1, ack in slot 2. A subsequent read of 100 returns 12'hABC with host_err=0.
- host read addr=76800 → mem_en stays 0; ack after 1 cycle with host_rdata=0, host_err=1.
- Back-to-back host reads held continuously over 8 clk with valid=1 → slot 0 never carries a host access. Ack spacing is ≥2 cycles with no lost or duplicated acks.
- rst asserted low in the H_ACK cycle → host_ack never pulses; all outputs 0 immediately. After release, the first pix_en behaves per the scan-out scenario.
